// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder:
//   - state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is illegal and
//                 is handled as IDLE by the FSM)
//   - MAX_WIDTH : largest supported operand width
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_adder_add_full_bit.sv
// -----------------------------------------------------------------------------
// half_add_cell / add_full_bit
// half_add_cell : single-bit half adder.
//   a_i, b_i      : input bits
//   sum_o         : a_i ^ b_i
//   carry_o       : a_i & b_i
// add_full_bit  : purely combinational one-bit full adder built from two
//                 half-adder cells plus an OR of their carries.
//   a, b, c_in    : input bits and carry-in
//   sum, c_out    : sum bit and carry-out
// -----------------------------------------------------------------------------
module half_add_cell (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule : half_add_cell

module add_full_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    half_add_cell u_ha0 (
        .a_i     (a),
        .b_i     (b),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    half_add_cell u_ha1 (
        .a_i     (ha0_sum),
        .b_i     (c_in),
        .sum_o   (sum),
        .carry_o (ha1_carry)
    );

    // The two half-adder carries can never both be 1, so OR equals XOR here.
    assign c_out = ha0_carry | ha1_carry;

endmodule : add_full_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit unsigned adder, one bit per clock, LSB first, using a
// single full-adder cell and a registered carry.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands a/b/c_in valid
//   in_ready   : operands accepted (high only in IDLE)
//   a, b       : WIDTH-bit operands
//   c_in       : carry-in
//   out_valid  : result valid (high only in DONE)
//   out_ready  : downstream accepts result
//   sum        : registered result, a+b+c_in mod 2^WIDTH
//   c_out      : registered carry-out of the full WIDTH-bit add
//   busy       : high in RUN or DONE
// WIDTH legal range: 2..MAX_WIDTH.
// Latency: WIDTH edges from the accepting edge to out_valid.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only WIDTH-1 partial bits need storing: the final bit comes straight
    // from the adder on the terminal edge.
    logic [WIDTH-2:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] ps_shift;

    add_full_bit u_fa (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign ps_shift = {fa_sum, ps_q};

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        ps_d      = ps_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_RUN: begin
                busy    = 1'b1;
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                ps_d    = ps_shift[WIDTH-1:1];
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = ps_shift;
                    cout_d  = fa_carry;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            // ST_IDLE, and the unused encoding which behaves as IDLE.
            default: begin
                in_ready = 1'b1;
                state_d  = ST_IDLE;
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; caller ensures the DUT is in IDLE.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a        = av;
        b        = bv;
        c_in     = cv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Accept, then check exact latency and the result.
    task automatic run_directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic cv, input logic [W-1:0] es, input logic ec);
        start_op(av, bv, cv);
        chk({tag, "_in_ready_low"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        for (int i = 1; i < W; i++) begin
            tick();
            chk({tag, "_early_valid"}, out_valid, 1'b0);
        end
        tick();
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_c_out"}, c_out, ec);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, out_valid, 1'b0);
        chk({tag, "_rel_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [W:0]   exp_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        bit           got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_c_out", c_out, 1'b0);

        // Basic add: 0x5A + 0x3C = 0x96
        run_directed("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        release_out("basic");

        // Backpressure: 0x01 + 0x02 held in DONE while new operands are offered
        run_directed("bp_first", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
        a         = 8'h11;
        b         = 8'h22;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_sum", sum, 8'h03);
            chk("bp_hold_c_out", c_out, 1'b0);
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1'b1);
        chk("bp_idle_valid", out_valid, 1'b0);
        chk("bp_idle_busy", busy, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_busy", busy, 1'b1);
        chk("bp_accept_ready", in_ready, 1'b0);
        for (int i = 1; i < W; i++) begin
            tick();
            chk("bp_early_valid", out_valid, 1'b0);
        end
        tick();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_sum", sum, 8'h33);
        chk("bp_c_out", c_out, 1'b0);
        release_out("bp");

        // Carry ripple and wrap
        run_directed("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        release_out("wrap");
        run_directed("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        release_out("allones");

        // Asynchronous reset after the 3rd RUN edge of 0xAA + 0x55
        start_op(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum, 8'h00);
        chk("arst_c_out", c_out, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("arst_no_valid", out_valid, 1'b0);
            chk("arst_in_ready_after", in_ready, 1'b1);
        end
        chk("arst_sum_after", sum, 8'h00);

        // Random back-to-back with random output stalls
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            ra       = W'($urandom);
            rb       = W'($urandom);
            rc       = 1'($urandom_range(0, 1));
            exp_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            chk("rand_in_ready", in_ready, 1'b1);
            start_op(ra, rb, rc);
            got = 1'b0;
            for (int k = 0; k < 64 && !got; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("rand_sum", sum, exp_full[W-1:0]);
                    chk("rand_c_out", c_out, exp_full[W]);
                    got = 1'b1;
                end
                tick();
            end
            out_ready = 1'b0;
            if (!got) begin
                chk("rand_timeout", 1'b0, 1'b1);
            end
            chk("rand_single_handshake", out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
